// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with a per-register pending-write scoreboard.
// Optional write-through bypass when REG_FILE_MP_BYPASS_EN is defined.
module reg_file_mp #(
    parameter  int WIDTH    = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*WIDTH-1:0]    rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_WR*WIDTH-1:0]    wr_data_i,
    input  logic                       sb_set_i,
    input  logic [ADDR_W-1:0]          sb_set_addr_i,
    input  logic                       sb_flush_i,
    output logic [NUM_REGS-1:0]        sb_busy_o
);

    logic [WIDTH-1:0]    mem [NUM_REGS];
    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;
    logic [ADDR_W-1:0]   rd_addr [NUM_RD];
    logic [ADDR_W-1:0]   wr_addr [NUM_WR];
    logic [WIDTH-1:0]    wr_data [NUM_WR];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_unpack
        assign rd_addr[p] = rd_addr_i[p*ADDR_W +: ADDR_W];
    end

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
        assign wr_addr[w] = wr_addr_i[w*ADDR_W +: ADDR_W];
        assign wr_data[w] = wr_data_i[w*WIDTH +: WIDTH];
    end

    // Later ports are assigned last, so the highest enabled port wins a conflict.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr[w] != '0)) begin
                    mem[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    // Priority low to high: hold, write-clear, set, flush; bit 0 pinned low.
    always_comb begin
        sb_d = sb_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w]) begin
                sb_d[wr_addr[w]] = 1'b0;
            end
        end
        if (sb_set_i) begin
            sb_d[sb_set_addr_i] = 1'b1;
        end
        if (sb_flush_i) begin
            sb_d = '0;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign sb_busy_o = sb_q;

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_o[p*WIDTH +: WIDTH] = (rd_addr[p] == '0) ? '0 : mem[rd_addr[p]];
            rd_busy_o[p]                = sb_q[rd_addr[p]];
`ifdef REG_FILE_MP_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (rd_addr[p] != '0) && (wr_addr[w] == rd_addr[p])) begin
                    rd_data_o[p*WIDTH +: WIDTH] = wr_data[w];
                    if (!(sb_set_i && (sb_set_addr_i == rd_addr[p]))) begin
                        rd_busy_o[p] = 1'b0;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (2 read ports, 2 write ports).
module tb_reg_file_mp;

    localparam int WIDTH    = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int NUM_WR   = 2;
    localparam int ADDR_W   = 5;

    logic                      clk_i = 1'b0;
    logic                      reset_i;
    logic [NUM_RD*ADDR_W-1:0]  rd_addr_i;
    logic [NUM_RD*WIDTH-1:0]   rd_data_o;
    logic [NUM_RD-1:0]         rd_busy_o;
    logic [NUM_WR-1:0]         wr_en_i;
    logic [NUM_WR*ADDR_W-1:0]  wr_addr_i;
    logic [NUM_WR*WIDTH-1:0]   wr_data_i;
    logic                      sb_set_i;
    logic [ADDR_W-1:0]         sb_set_addr_i;
    logic                      sb_flush_i;
    logic [NUM_REGS-1:0]       sb_busy_o;

    int checks = 0;
    int passed = 0;

    reg_file_mp #(
        .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .sb_set_i(sb_set_i), .sb_set_addr_i(sb_set_addr_i),
        .sb_flush_i(sb_flush_i), .sb_busy_o(sb_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en_i    = '0;
        sb_set_i   = 1'b0;
        sb_flush_i = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
        rd_addr_i[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_wr(input int w, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        wr_en_i[w]                    = 1'b1;
        wr_addr_i[w*ADDR_W +: ADDR_W] = a;
        wr_data_i[w*WIDTH +: WIDTH]   = d;
    endtask

    function automatic logic [WIDTH-1:0] rd(input int p);
        return rd_data_o[p*WIDTH +: WIDTH];
    endfunction

    task automatic test_reset();
        int bad;
        reset_i = 1'b1;
        idle();
        set_wr(0, 5'd3, 32'hFFFF_FFFF);
        sb_set_i      = 1'b1;
        sb_set_addr_i = 5'd3;
        tick();
        reset_i = 1'b0;
        idle();
        #1;
        checks++;
        if (sb_busy_o !== '0) $display("FAIL reset_sb_busy actual=%h required=0", sb_busy_o);
        else passed++;
        bad = 0;
        for (int a = 0; a < NUM_REGS; a++) begin
            set_rd(0, a[ADDR_W-1:0]);
            set_rd(1, a[ADDR_W-1:0]);
            #1;
            checks++;
            if (rd(0) !== 32'h0 || rd(1) !== 32'h0 || rd_busy_o !== 2'b00) begin
                $display("FAIL reset_read x%0d actual=%h/%h busy=%b required=0/0 busy=00",
                         a, rd(0), rd(1), rd_busy_o);
                bad++;
            end else passed++;
        end
    endtask

    task automatic test_basic_write();
        set_wr(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        set_rd(1, 5'd5);
        set_rd(0, 5'd0);
        #1;
        checks++;
        if (rd(1) !== 32'hDEAD_BEEF) $display("FAIL basic_x5 actual=%h required=deadbeef", rd(1));
        else passed++;
        set_wr(0, 5'd0, 32'h0000_1234);
        #1;
        checks++;
        if (rd(0) !== 32'h0) $display("FAIL x0_same_cycle actual=%h required=0", rd(0));
        else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (rd(0) !== 32'h0) $display("FAIL x0_after_write actual=%h required=0", rd(0));
        else passed++;
    endtask

    task automatic test_conflict();
        set_wr(0, 5'd7, 32'h0000_1111);
        set_wr(1, 5'd7, 32'h0000_2222);
        tick();
        idle();
        set_rd(0, 5'd7);
        #1;
        checks++;
        if (rd(0) !== 32'h0000_2222) $display("FAIL conflict_x7 actual=%h required=00002222", rd(0));
        else passed++;
        set_wr(1, 5'd8, 32'h0000_8888);
        set_wr(0, 5'd8, 32'h0000_9999);
        tick();
        idle();
        set_rd(1, 5'd8);
        #1;
        checks++;
        if (rd(1) !== 32'h0000_8888) $display("FAIL conflict_x8 actual=%h required=00008888", rd(1));
        else passed++;
    endtask

    task automatic test_scoreboard();
        sb_set_i      = 1'b1;
        sb_set_addr_i = 5'd9;
        tick();
        idle();
        set_rd(0, 5'd9);
        set_rd(1, 5'd5);
        #1;
        checks++;
        if (rd_busy_o !== 2'b01 || sb_busy_o !== 32'h0000_0200)
            $display("FAIL sb_set_x9 actual=busy %b sb %h required=busy 01 sb 00000200", rd_busy_o, sb_busy_o);
        else passed++;
        sb_set_i      = 1'b1;
        sb_set_addr_i = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if (sb_busy_o !== 32'h0000_0200) $display("FAIL sb_set_x0 actual=%h required=00000200", sb_busy_o);
        else passed++;
        set_wr(0, 5'd9, 32'h0000_0055);
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy_o[0] !== 1'b0 || rd(0) !== 32'h0000_0055)
            $display("FAIL sb_clear_x9 actual=busy %b data %h required=busy 0 data 00000055", rd_busy_o[0], rd(0));
        else passed++;
        sb_set_i      = 1'b1;
        sb_set_addr_i = 5'd9;
        set_wr(1, 5'd9, 32'h0000_0077);
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy_o[0] !== 1'b1 || rd(0) !== 32'h0000_0077)
            $display("FAIL sb_set_beats_clear actual=busy %b data %h required=busy 1 data 00000077", rd_busy_o[0], rd(0));
        else passed++;
    endtask

    task automatic test_flush();
        set_wr(0, 5'd9, 32'h0000_0099);
        sb_set_i      = 1'b1;
        sb_set_addr_i = 5'd3;
        tick();
        idle();
        sb_set_i      = 1'b1;
        sb_set_addr_i = 5'd4;
        tick();
        idle();
        #1;
        checks++;
        if (sb_busy_o !== 32'h0000_0018) $display("FAIL flush_pre actual=%h required=00000018", sb_busy_o);
        else passed++;
        sb_flush_i    = 1'b1;
        sb_set_i      = 1'b1;
        sb_set_addr_i = 5'd6;
        set_wr(0, 5'd10, 32'h0000_ABCD);
        tick();
        idle();
        set_rd(1, 5'd10);
        #1;
        checks++;
        if (sb_busy_o !== '0 || rd(1) !== 32'h0000_ABCD)
            $display("FAIL flush actual=sb %h x10 %h required=sb 0 x10 0000abcd", sb_busy_o, rd(1));
        else passed++;
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp_data;
        logic             exp_busy;
        set_wr(0, 5'd12, 32'h0000_0012);
        tick();
        idle();
        sb_set_i      = 1'b1;
        sb_set_addr_i = 5'd12;
        tick();
        idle();
        set_rd(0, 5'd12);
        set_wr(0, 5'd12, 32'hA5A5_A5A5);
        #1;
`ifdef REG_FILE_MP_BYPASS_EN
        exp_data = 32'hA5A5_A5A5;
        exp_busy = 1'b0;
`else
        exp_data = 32'h0000_0012;
        exp_busy = 1'b1;
`endif
        checks++;
        if (rd(0) !== exp_data || rd_busy_o[0] !== exp_busy)
            $display("FAIL bypass_same_cycle actual=data %h busy %b required=data %h busy %b",
                     rd(0), rd_busy_o[0], exp_data, exp_busy);
        else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (rd(0) !== 32'hA5A5_A5A5 || rd_busy_o[0] !== 1'b0)
            $display("FAIL bypass_next_cycle actual=data %h busy %b required=data a5a5a5a5 busy 0", rd(0), rd_busy_o[0]);
        else passed++;
        set_rd(1, 5'd13);
        set_wr(0, 5'd13, 32'h0000_0001);
        set_wr(1, 5'd13, 32'h0000_0002);
        #1;
`ifdef REG_FILE_MP_BYPASS_EN
        exp_data = 32'h0000_0002;
`else
        exp_data = 32'h0000_0000;
`endif
        checks++;
        if (rd(1) !== exp_data) $display("FAIL bypass_priority actual=%h required=%h", rd(1), exp_data);
        else passed++;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 32'h1000_0001;
        vals[1] = 32'h2000_0002;
        vals[2] = 32'h3000_0003;
        vals[3] = 32'h4000_0004;
        for (int i = 0; i < 4; i++) begin
            idle();
            set_wr(i % 2, 5'(20 + i), vals[i]);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i += 2) begin
            set_rd(0, 5'(20 + i));
            set_rd(1, 5'(21 + i));
            #1;
            checks++;
            if (rd(0) !== vals[i] || rd(1) !== vals[i+1])
                $display("FAIL b2b_x%0d actual=%h/%h required=%h/%h", 20 + i, rd(0), rd(1), vals[i], vals[i+1]);
            else passed++;
        end
    endtask

    initial begin
        reset_i       = 1'b1;
        rd_addr_i     = '0;
        wr_en_i       = '0;
        wr_addr_i     = '0;
        wr_data_i     = '0;
        sb_set_i      = 1'b0;
        sb_set_addr_i = '0;
        sb_flush_i    = 1'b0;
        tick();
        test_reset();
        test_basic_write();
        test_conflict();
        test_scoreboard();
        test_flush();
        test_bypass();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
